netdma_rx_pkt_buffer: RTL and testbench
=======================================

# netdma_rx_pkt_buffer

Store-and-forward receive packet buffer sitting directly upstream of the netdma sink interface, between the Ethernet MAC receive stream and the writemaster. Frames are held until their last word arrives error-free and only then released downstream. Frames that arrive with an error flag, are truncated, or do not fit in the buffer are dropped whole, so the writemaster never starts a descriptor for a bad or partial frame. Drop and accept counts are exported for the dispatcher status registers.

## Interface

Parameters:
- DATA_WIDTH, 64: stream data width in bits; multiple of 8.
- DEPTH_WORDS, 512: buffer depth in data words; power of two, at least 16.
- EMPTY_W, $clog2(DATA_WIDTH/8): width of the empty-bytes field.

Ports:
- clk_i  in  1  system clock, shared with netdma.
- rst_i  in  1  reset; asynchronous, active-high.
- in_valid_i  in  1  MAC word valid; the MAC has no backpressure.
- in_data_i  in  DATA_WIDTH  MAC data word.
- in_sop_i  in  1  first word of frame.
- in_eop_i  in  1  last word of frame.
- in_empty_i  in  EMPTY_W  unused bytes in the eop word; ignored when eop is low.
- in_error_i  in  1  frame error (CRC/PHY); sampled only on the eop word.
- out_valid_o  out  1  downstream word valid (to the netdma sink).
- out_ready_i  in  1  downstream ready.
- out_data_o  out  DATA_WIDTH  data.
- out_sop_o, out_eop_o  out  1 each  frame delimiters.
- out_empty_o  out  EMPTY_W  unused bytes on the eop word.
- drop_cnt_o  out  16  frames dropped; saturates at 16'hFFFF.
- frame_cnt_o  out  16  frames committed; wraps at 16'hFFFF.

## Operation

- Storage word = {sop, eop, empty, data}, written at wr_ptr. Pointers are $clog2(DEPTH_WORDS)+1 bits, using the MSB for full/empty disambiguation.
- Three pointers are kept:
  - wr_ptr: speculative write pointer.
  - commit_ptr: end of the last good frame.
  - rd_ptr: read pointer.
- Full condition: wr_ptr − rd_ptr == DEPTH_WORDS.
- Write FSM states:
  - IDLE: in_valid & in_sop → write the word, go to RECV. A word without sop is ignored and counts no drop.
  - RECV: each valid word is written.
    - eop & !error → commit_ptr ← wr_ptr+1, frame_cnt++, go to IDLE.
    - eop & error → wr_ptr ← commit_ptr, drop_cnt++, go to IDLE.
  - RECV, sop without a prior eop: drop the partial frame (wr_ptr ← commit_ptr, drop_cnt++), write the new sop word at commit_ptr, stay in RECV.
  - Valid word while full (IDLE or RECV): wr_ptr ← commit_ptr, drop_cnt++. Go to DROP, or to IDLE if the word carries eop.
  - DROP: discard words until eop, then go to IDLE. A sop seen in DROP starts a new frame (go to RECV) when not full.
- Single-word frame (sop & eop together) follows the RECV eop rules in one cycle.
- Read side:
  - Words are readable only while rd_ptr != commit_ptr.
  - RAM is synchronous-read; a one-entry output register is prefetched.
  - Output holds stable while out_valid & !out_ready (AXI-style: valid must not drop without a transfer).
- Reset mid-operation: all pointers go to 0, FSM goes to IDLE, and buffer contents are discarded, including a partially transferred output frame.

## Timing

- Reset values: out_valid_o=0, out_sop_o=0, out_eop_o=0, out_data_o=0, out_empty_o=0, drop_cnt_o=0, frame_cnt_o=0.
- Latency: with an empty buffer and out_ready=1, the first word of a frame appears at out_valid_o 2 cycles after the cycle in which its eop word is presented.
- Throughput: one word per cycle on both sides at the same time.
- Back-to-back frames: a new sop in the cycle after eop is accepted without loss.
- Counters update on the clock edge after the deciding word.
- Simultaneous commit and read: the read side sees the new commit_ptr one cycle later.
- Space freed by a read in the same cycle as a full check is not visible to that check; the check uses registered pointers.

## Structure

- netdma_pkg gains:
  - typedef rx_buf_word_t, the packed {sop, eop, empty, data} storage word.
  - typedef rx_wr_state_t: IDLE, RECV, DROP.
- Sub-module netdma_sdp_ram: simple dual-port RAM with one write port, one registered-read port, and parameterised width and depth. It is inferred memory, reused later for the TX side.
- Pointer arithmetic and the counters stay in the top of this block.

## Test plan

- Single 8-word good frame, out_ready=1 → 8 words out, sop on word 0, eop on word 7, frame_cnt=1; first out_valid exactly 2 cycles after input eop.
- 4-word frame with in_error on eop, then a good 3-word frame → only the 3-word frame is emitted, drop_cnt=1, frame_cnt=1.
- DEPTH_WORDS=16, out_ready=0, 20-word frame → dropped; a following 5-word frame is stored; raise out_ready → only the 5-word frame is emitted, drop_cnt=1.
- sop at word 3 of a frame with no eop, then a 2-word good frame → one drop, 2-word frame emitted intact.
- Random out_ready at 30% with back-to-back 1..64-word frames → output stream equals the input good frames in order; valid never drops without a transfer.
- Assert rst_i while out_valid=1 mid-frame → all outputs 0 the same cycle; after release, a new 1-word frame is emitted normally.

Source files
------------

// File: rtl/netdma_pkg.sv
// Shared types for the netdma receive path.
package netdma_pkg;

  // Default stream geometry of the receive buffer.
  localparam int RX_DATA_W  = 64;
  localparam int RX_EMPTY_W = 3;

  // One buffer entry: frame delimiters, byte-empty count and payload.
  // The buffer top packs the same field order for any parameterisation.
  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [RX_EMPTY_W-1:0] empty;
    logic [RX_DATA_W-1:0]  data;
  } rx_buf_word_t;

  // Write-side frame acceptance states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } rx_wr_state_t;

  // 16-bit saturating add of a small increment.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/netdma_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register holds its value while rd_en is low.
module netdma_sdp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/netdma_rx_pkt_buffer.sv
// Store-and-forward receive packet buffer. Frames are written speculatively
// and only become readable once their eop word arrives without error; bad,
// truncated or oversized frames are rewound and counted as drops.
//
// Output handshake: a word transfers on a cycle where out_valid_o and
// out_ready_i are both high. Once out_valid_o is raised it stays high and
// all output fields stay unchanged until that transfer happens.
module netdma_rx_pkt_buffer
  import netdma_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH_WORDS = 512,
  parameter int EMPTY_W     = $clog2(DATA_WIDTH/8)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_sop_i,
  input  logic                  in_eop_i,
  input  logic [EMPTY_W-1:0]    in_empty_i,
  input  logic                  in_error_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_sop_o,
  output logic                  out_eop_o,
  output logic [EMPTY_W-1:0]    out_empty_o,
  output logic [15:0]           drop_cnt_o,
  output logic [15:0]           frame_cnt_o,
  output logic [1:0]            wr_state
);

  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam int PW     = AW + 1;
  localparam int WORD_W = DATA_WIDTH + EMPTY_W + 2;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH_WORDS);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  rx_wr_state_t state_q, state_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] fill;
  logic          full;

  logic [15:0] drop_cnt_q, frame_cnt_q;
  logic [1:0]  drop_inc;
  logic        frame_inc;
  logic        restart;

  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;

  logic have_data;
  logic rd_en;
  logic out_valid_q;

  // Full is judged on registered pointers only; a read in the same cycle
  // does not make room for the word being checked.
  assign fill = wr_ptr_q - rd_ptr_q;
  assign full = (fill == DEPTH_P);

  // Empty bytes only mean something on the eop word; store zero elsewhere.
  assign ram_wdata = {in_sop_i, in_eop_i, (in_eop_i ? in_empty_i : {EMPTY_W{1'b0}}), in_data_i};

  // A sop arriving while a frame is open abandons the open frame.
  assign restart = (state_q == RECV);

  // Write FSM: next state, write strobe, pointer rewinds and counter events.
  // Outside RECV the write pointer always equals the commit pointer, so a
  // new frame always starts at commit_ptr.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    ram_we       = 1'b0;
    ram_waddr    = wr_ptr_q[AW-1:0];
    drop_inc     = 2'd0;
    frame_inc    = 1'b0;
    if (in_valid_i) begin
      if (full && (in_sop_i || state_q == RECV)) begin
        // No room for a word that belongs to a frame: drop the frame whole.
        wr_ptr_d = commit_ptr_q;
        drop_inc = 2'd1;
        state_d  = in_eop_i ? IDLE : DROP;
      end else if (in_sop_i) begin
        ram_we    = 1'b1;
        ram_waddr = commit_ptr_q[AW-1:0];
        if (in_eop_i && in_error_i) begin
          wr_ptr_d = commit_ptr_q;
          drop_inc = restart ? 2'd2 : 2'd1;
          state_d  = IDLE;
        end else if (in_eop_i) begin
          commit_ptr_d = commit_ptr_q + PTR_ONE;
          wr_ptr_d     = commit_ptr_q + PTR_ONE;
          frame_inc    = 1'b1;
          drop_inc     = restart ? 2'd1 : 2'd0;
          state_d      = IDLE;
        end else begin
          wr_ptr_d = commit_ptr_q + PTR_ONE;
          drop_inc = restart ? 2'd1 : 2'd0;
          state_d  = RECV;
        end
      end else if (state_q == RECV) begin
        ram_we = 1'b1;
        if (in_eop_i && in_error_i) begin
          wr_ptr_d = commit_ptr_q;
          drop_inc = 2'd1;
          state_d  = IDLE;
        end else if (in_eop_i) begin
          commit_ptr_d = wr_ptr_q + PTR_ONE;
          wr_ptr_d     = wr_ptr_q + PTR_ONE;
          frame_inc    = 1'b1;
          state_d      = IDLE;
        end else begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
      end else if (state_q == DROP && in_eop_i) begin
        state_d = IDLE;
      end
    end
  end

  // Write-side state, pointers and status counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      drop_cnt_q   <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      drop_cnt_q   <= sat_add16(drop_cnt_q, drop_inc);
      frame_cnt_q  <= frame_cnt_q + 16'(frame_inc);
    end
  end

  // Read side: the RAM read register is the output register. A read is
  // issued whenever committed data exists and the output is empty or
  // draining this cycle, giving one word per cycle under full throughput.
  assign have_data = (rd_ptr_q != commit_ptr_q);
  assign rd_en     = have_data && (!out_valid_q || out_ready_i);

  // Read pointer and output valid flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr_q    <= rd_ptr_q + PTR_ONE;
        out_valid_q <= 1'b1;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  netdma_sdp_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk_i),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (ram_rdata)
  );

  // Fields are forced to zero whenever no word is presented, so reset
  // clears every output immediately.
  assign out_valid_o = out_valid_q;
  assign out_sop_o   = out_valid_q & ram_rdata[WORD_W-1];
  assign out_eop_o   = out_valid_q & ram_rdata[WORD_W-2];
  assign out_empty_o = out_valid_q ? ram_rdata[DATA_WIDTH +: EMPTY_W] : {EMPTY_W{1'b0}};
  assign out_data_o  = out_valid_q ? ram_rdata[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};

  assign drop_cnt_o  = drop_cnt_q;
  assign frame_cnt_o = frame_cnt_q;
  assign wr_state    = state_q;

endmodule

// File: tb/tb_netdma_rx_pkt_buffer.sv
// Bench for netdma_rx_pkt_buffer: a default-depth instance and a 16-word
// instance share one stimulus; a selector picks which one the scoreboard
// watches. Expected words come from the frames the bench decides are good.
module tb_netdma_rx_pkt_buffer;

  localparam int DW = 64;
  localparam int EW = 3;
  localparam int WW = DW + EW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared stimulus ----------------
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          in_sop   = 1'b0;
  logic          in_eop   = 1'b0;
  logic [EW-1:0] in_empty = '0;
  logic          in_error = 1'b0;
  logic          out_ready = 1'b0;

  logic          b_valid, b_sop, b_eop;
  logic [DW-1:0] b_data;
  logic [EW-1:0] b_empty;
  logic [15:0]   b_drop, b_frame;
  logic [1:0]    b_state;

  logic          s_valid, s_sop, s_eop;
  logic [DW-1:0] s_data;
  logic [EW-1:0] s_empty;
  logic [15:0]   s_drop, s_frame;
  logic [1:0]    s_state;

  netdma_rx_pkt_buffer #(.DATA_WIDTH(DW), .DEPTH_WORDS(512), .EMPTY_W(EW)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_sop_i(in_sop), .in_eop_i(in_eop),
    .in_empty_i(in_empty), .in_error_i(in_error),
    .out_valid_o(b_valid), .out_ready_i(out_ready), .out_data_o(b_data),
    .out_sop_o(b_sop), .out_eop_o(b_eop), .out_empty_o(b_empty),
    .drop_cnt_o(b_drop), .frame_cnt_o(b_frame), .wr_state(b_state)
  );

  netdma_rx_pkt_buffer #(.DATA_WIDTH(DW), .DEPTH_WORDS(16), .EMPTY_W(EW)) dut_small (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_sop_i(in_sop), .in_eop_i(in_eop),
    .in_empty_i(in_empty), .in_error_i(in_error),
    .out_valid_o(s_valid), .out_ready_i(out_ready), .out_data_o(s_data),
    .out_sop_o(s_sop), .out_eop_o(s_eop), .out_empty_o(s_empty),
    .drop_cnt_o(s_drop), .frame_cnt_o(s_frame), .wr_state(s_state)
  );

  logic sel_small = 1'b0;
  logic          m_valid;
  logic [WW-1:0] m_word;
  assign m_valid = sel_small ? s_valid : b_valid;
  assign m_word  = sel_small ? {s_sop, s_eop, s_empty, s_data} : {b_sop, b_eop, b_empty, b_data};

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [WW-1:0] exp_q[$];

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic          mon_en = 1'b0;
  logic          lat_arm = 1'b0;
  int            first_valid_cyc = -1;
  logic          prev_stall = 1'b0;
  logic [WW-1:0] prev_word = '0;

  // Output monitor: transfers against the expected queue, plus hold-while-stalled.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (prev_stall) begin
        check("hold_valid", WW'(m_valid), WW'(1));
        check("hold_word", m_word, prev_word);
      end
      if (lat_arm && m_valid) begin
        first_valid_cyc = cyc;
        lat_arm = 1'b0;
      end
      if (m_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected no transfer", m_word);
        end else begin
          check("out_word", m_word, exp_q.pop_front());
        end
      end
      prev_stall = m_valid && !out_ready;
      prev_word  = m_word;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  logic rnd_ready = 1'b0;
  int   eop_cyc = 0;

  task automatic step();
    if (rnd_ready) out_ready = ($urandom_range(0, 99) < 30);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0; in_empty = '0;
    repeat (n) step();
  endtask

  task automatic send_word(input logic sop, input logic eop, input logic err,
                           input logic [EW-1:0] emp, input logic [DW-1:0] d);
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_error = err; in_empty = emp; in_data = d;
    step();
  endtask

  // keep: frame is expected at the output; add_eop=0 leaves the frame open.
  // The error flag on non-eop words is random noise that must be ignored.
  task automatic send_frame(input int len, input logic err, input logic keep, input logic add_eop);
    logic [DW-1:0] d;
    logic [EW-1:0] e;
    logic s, last, ebit;
    for (int i = 0; i < len; i++) begin
      d    = {$urandom, $urandom};
      s    = (i == 0);
      last = add_eop && (i == len - 1);
      e    = last ? EW'($urandom_range(0, 7)) : '0;
      ebit = last ? err : 1'($urandom_range(0, 1));
      if (keep) exp_q.push_back({s, last, e, d});
      if (last) eop_cyc = cyc;
      send_word(s, last, ebit, e, d);
    end
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    idle(1);
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    idle(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  // kind: 0 complete frame, 1 frame left open (no eop), 2 stray non-sop word.
  // exp_drop/exp_frame are the cumulative counter values after the row.
  typedef struct {
    int   kind;
    int   len;
    logic err;
    int   exp_drop;
    int   exp_frame;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int total, n_drop, n_good, len;
    logic err;

    vecs[0] = '{0, 8, 1'b0, 0, 1};
    vecs[1] = '{0, 4, 1'b1, 1, 1};
    vecs[2] = '{0, 3, 1'b0, 1, 2};
    vecs[3] = '{1, 3, 1'b0, 1, 2};
    vecs[4] = '{0, 2, 1'b0, 2, 3};
    vecs[5] = '{0, 1, 1'b0, 2, 4};
    vecs[6] = '{0, 1, 1'b1, 3, 4};
    vecs[7] = '{2, 1, 1'b0, 3, 4};

    do_reset();
    check("rst_valid", WW'(b_valid), '0);
    check("rst_sop",   WW'(b_sop),   '0);
    check("rst_eop",   WW'(b_eop),   '0);
    check("rst_data",  WW'(b_data),  '0);
    check("rst_empty", WW'(b_empty), '0);
    check("rst_drop",  WW'(b_drop),  '0);
    check("rst_frame", WW'(b_frame), '0);

    mon_en = 1'b1;
    out_ready = 1'b1;

    // Table rows: good, errored, open and stray frames.
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        lat_arm = 1'b1;
        first_valid_cyc = -1;
      end
      case (vecs[i].kind)
        0: send_frame(vecs[i].len, vecs[i].err, !vecs[i].err, 1'b1);
        1: send_frame(vecs[i].len, 1'b0, 1'b0, 1'b0);
        default: send_word(1'b0, 1'b1, 1'b0, 3'd0, {$urandom, $urandom});
      endcase
      drain(200);
      if (i == 0) check("latency", WW'(first_valid_cyc - eop_cyc), WW'(2));
      check("tbl_drop",  WW'(b_drop),  WW'(vecs[i].exp_drop));
      check("tbl_frame", WW'(b_frame), WW'(vecs[i].exp_frame));
    end

    // Back to back: open frame, then a sop+eop frame, then a 4-word frame.
    send_frame(3, 1'b0, 1'b0, 1'b0);
    send_frame(1, 1'b0, 1'b1, 1'b1);
    send_frame(4, 1'b0, 1'b1, 1'b1);
    drain(200);
    check("b2b_drop",  WW'(b_drop),  WW'(4));
    check("b2b_frame", WW'(b_frame), WW'(6));

    // Oversized frame into a 16-word buffer with the output stalled.
    do_reset();
    sel_small = 1'b1;
    send_frame(20, 1'b0, 1'b0, 1'b1);
    send_frame(5, 1'b0, 1'b1, 1'b1);
    idle(6);
    check("ovf_drop",  WW'(s_drop),  WW'(1));
    check("ovf_frame", WW'(s_frame), WW'(1));
    check("ovf_valid_held", WW'(s_valid), WW'(1));
    out_ready = 1'b1;
    drain(100);
    check("ovf_drop_end", WW'(s_drop), WW'(1));

    // Exactly 16 words fit; the next frame arrives to a full buffer.
    do_reset();
    send_frame(16, 1'b0, 1'b1, 1'b1);
    send_frame(2, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("full_drop",  WW'(s_drop),  WW'(1));
    check("full_frame", WW'(s_frame), WW'(1));
    out_ready = 1'b1;
    drain(100);
    sel_small = 1'b0;

    // Random frames with 30% ready; total stays below the 512-word depth.
    do_reset();
    rnd_ready = 1'b1;
    total = 0; n_drop = 0; n_good = 0;
    while (total + 64 <= 480) begin
      len = $urandom_range(1, 64);
      err = ($urandom_range(0, 4) == 0);
      send_frame(len, err, !err, 1'b1);
      total += len;
      if (err) n_drop++; else n_good++;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain(4000);
    rnd_ready = 1'b0;
    check("rnd_drop",  WW'(b_drop),  WW'(n_drop));
    check("rnd_frame", WW'(b_frame), WW'(n_good));

    // Reset while a frame is mid-transfer and stalled.
    do_reset();
    out_ready = 1'b1;
    send_frame(6, 1'b0, 1'b1, 1'b1);
    idle(2);
    out_ready = 1'b0;
    step();
    check("pre_rst_valid", WW'(b_valid), WW'(1));
    check("pre_rst_frame", WW'(b_frame), WW'(1));
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_valid", WW'(b_valid), '0);
    check("mid_rst_sop",   WW'(b_sop),   '0);
    check("mid_rst_eop",   WW'(b_eop),   '0);
    check("mid_rst_data",  WW'(b_data),  '0);
    check("mid_rst_empty", WW'(b_empty), '0);
    check("mid_rst_frame", WW'(b_frame), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    send_frame(1, 1'b0, 1'b1, 1'b1);
    drain(50);
    check("post_rst_frame", WW'(b_frame), WW'(1));
    check("post_rst_drop",  WW'(b_drop),  '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
